regfile_wb_port: RTL and testbench

//  Integer register file for the pipelined RISC-V core. It is the receiving end of the Writeback stage result bus.
//  - Writes: ResultW is written into register RDW when RegWriteW is high.
//  - Reads: two combinational ports serve the Decode stage, with same-cycle write-to-read bypass.
//  - After every reset, a sequential init engine clears the array and asserts Ready when done.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/regfile_init_seq.sv | 64 ++++++
 rtl/regfile_wb_port.sv | 121 ++++++++++++
 tb/tb_regfile_wb_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared constants and types for the pipelined RISC-V core.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Integer datapath width and register-file address width.
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Architectural index of the stack pointer (x2).
    localparam int REG_SP = 2;

    // Register-file sequencing: clearing the array, then normal operation.
    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_init_seq
// Purpose  : Post-reset init engine. Walks x1..x(NREGS-1) once, one register
//            per cycle, loading SP_RESET into x2 and zero elsewhere, then
//            declares the register file ready.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_init_seq
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              NREGS    = 32,
    parameter int              AW       = riscv_pkg::REG_AW,
    parameter logic [XLEN-1:0] SP_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_we_o,
    output logic [AW-1:0]   init_addr_o,
    output logic [XLEN-1:0] init_data_o,
    output logic            ready_o
);

    localparam logic [AW-1:0] C_LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] C_SP_IDX   = AW'(REG_SP);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and index registers; reset restarts the walk at x1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_INIT;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Advance the index while initialising; leave INIT after the last register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == RF_INIT) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == C_LAST_IDX) begin
                state_d = RF_RUN;
            end
        end
    end

    // Init write port and Ready, decoded purely from registered state
    // (the write is suppressed on a reset edge so rst never touches the array).
    always_comb begin
        init_we_o   = (state_q == RF_INIT) && !rst;
        init_addr_o = idx_q;
        init_data_o = (idx_q == C_SP_IDX) ? SP_RESET : '0;
        ready_o     = (state_q == RF_RUN);
    end

endmodule : regfile_init_seq
`default_nettype wire

// File: rtl/regfile_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_port
// Purpose  : Integer register file fed by the Writeback result bus. One
//            write port shared between the init engine and Writeback, two
//            combinational read ports with same-cycle write bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_port
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              NREGS    = 32,
    parameter int              AW       = riscv_pkg::REG_AW,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            Ready,
    output logic            WrDropped
);

    // x0 has no storage; entries 1..NREGS-1 are flops so reads have no latency.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic            wr_dropped_q;

    logic            w_init_we;
    logic [AW-1:0]   w_init_addr;
    logic [XLEN-1:0] w_init_data;
    logic            w_ready;
    logic            w_wb_req;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;

    regfile_init_seq #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .AW       (AW),
        .SP_RESET (SP_RESET)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .init_we_o   (w_init_we),
        .init_addr_o (w_init_addr),
        .init_data_o (w_init_data),
        .ready_o     (w_ready)
    );

    // Writeback request that targets a real register (x0 writes are no-ops).
    assign w_wb_req = RegWriteW && (RDW != '0);

    // Single array write port: init engine owns it until Ready, then Writeback.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_init_addr;
        w_wdata = w_init_data;
        if (w_ready) begin
            w_we    = w_wb_req && !rst;
            w_waddr = RDW;
            w_wdata = ResultW;
        end else begin
            w_we    = w_init_we;
        end
    end

    // Register array; addresses >= NREGS match no entry and are not written.
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (w_we && (w_waddr == AW'(gi))) begin
                regs_q[gi] <= w_wdata;
            end
        end
    end

    // Sticky flag for Writeback writes lost while the array is initialising.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_dropped_q <= 1'b0;
        end else if (!w_ready && w_wb_req) begin
            wr_dropped_q <= 1'b1;
        end
    end

    // One read port: zero for x0 / not ready, bypass a same-cycle write,
    // otherwise the stored value (out-of-range addresses fall through to 0).
    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        if (w_ready && (addr != '0)) begin
            if (RegWriteW && (RDW == addr)) begin
                v = ResultW;
            end else begin
                for (int i = 1; i < NREGS; i++) begin
                    if (addr == AW'(i)) begin
                        v = regs_q[i];
                    end
                end
            end
        end
        return v;
    endfunction

    // Combinational read ports toward Decode.
    always_comb begin
        RD1 = f_read(A1);
        RD2 = f_read(A2);
    end

    assign Ready     = w_ready;
    assign WrDropped = wr_dropped_q;

endmodule : regfile_wb_port
`default_nettype wire

// File: tb/tb_regfile_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_port
// Purpose  : Self-checking bench for regfile_wb_port against a behavioural
//            register-file model (cycle count to Ready, plain array storage).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_port;

    localparam int          C_XLEN  = 32;
    localparam int          C_NREGS = 32;
    localparam int          C_AW    = 5;
    localparam logic [31:0] C_SP    = 32'h0001_0000;
    localparam int          C_INIT_CYCLES = C_NREGS - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [C_AW-1:0] rdw, a1, a2;
    logic [31:0]     res;
    logic [31:0]     rd1, rd2;
    logic            ready, wrd;

    always #5 clk = ~clk;

    regfile_wb_port #(
        .XLEN     (C_XLEN),
        .NREGS    (C_NREGS),
        .AW       (C_AW),
        .SP_RESET (C_SP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (we),
        .RDW       (rdw),
        .ResultW   (res),
        .A1        (a1),
        .A2        (a2),
        .RD1       (rd1),
        .RD2       (rd2),
        .Ready     (ready),
        .WrDropped (wrd)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural contents, edges since reset, flags.
    logic [31:0] mem [C_NREGS];
    int          m_cnt;
    bit          m_ready;
    bit          m_drop;

    function automatic logic [31:0] m_read(input logic [C_AW-1:0] a);
        if (a == 0 || !m_ready) return 32'h0;
        if (we && rdw == a)     return res;
        return mem[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".RD1"},   rd1, m_read(a1));
        chk({tag, ".RD2"},   rd2, m_read(a2));
        chk({tag, ".Ready"}, {31'b0, ready}, {31'b0, m_ready});
        chk({tag, ".WrDrp"}, {31'b0, wrd},   {31'b0, m_drop});
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            m_drop  = 1'b0;
        end else if (!m_ready) begin
            if (we && rdw != 0) m_drop = 1'b1;
            m_cnt++;
            if (m_cnt == C_INIT_CYCLES) begin
                m_ready = 1'b1;
                for (int i = 0; i < C_NREGS; i++) mem[i] = 32'h0;
                mem[2] = C_SP;
            end
        end else if (we && rdw != 0) begin
            mem[rdw] = res;
        end
        #1;
    endtask

    task automatic drive(input bit r, input bit w, input logic [C_AW-1:0] d,
                         input logic [31:0] v, input logic [C_AW-1:0] x,
                         input logic [C_AW-1:0] y);
        rst = r; we = w; rdw = d; res = v; a1 = x; a2 = y;
        #1;
    endtask

    task automatic step(input string tag, input bit r, input bit w,
                        input logic [C_AW-1:0] d, input logic [31:0] v,
                        input logic [C_AW-1:0] x, input logic [C_AW-1:0] y);
        drive(r, w, d, v, x, y);
        check_all(tag);
        tick();
    endtask

    task automatic run_init(input string tag);
        for (int k = 0; k < C_INIT_CYCLES; k++) begin
            step(tag, 1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 31)), 5'd2);
        end
    endtask

    initial begin
        m_cnt = 0; m_ready = 1'b0; m_drop = 1'b0;
        for (int i = 0; i < C_NREGS; i++) mem[i] = 32'h0;

        // T1: two reset cycles (first one before DUT state is defined).
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        tick();
        step("T1.rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        run_init("T1.init");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        chk("T1.sp",    rd1, 32'h0001_0000);
        chk("T1.x5",    rd2, 32'h0);
        chk("T1.ready", {31'b0, ready}, 32'h1);
        check_all("T1.run");
        tick();

        // T2: write x7 with bypass, then read back from the array.
        drive(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd1);
        chk("T2.bypass", rd1, 32'hDEAD_BEEF);
        check_all("T2.wr");
        tick();
        drive(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
        chk("T2.array", rd1, 32'hDEAD_BEEF);
        check_all("T2.rd");
        tick();

        // T3: x0 write is silently ignored.
        step("T3.wr", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step("T3.rd", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("T3.drop", {31'b0, wrd}, 32'h0);

        // T5: write x3, reset in RUN, everything re-initialised.
        step("T5.wr", 1'b0, 1'b1, 5'd3, 32'h0000_A5A5, 5'd3, 5'd7);
        step("T5.rst", 1'b1, 1'b1, 5'd4, 32'h1111_1111, 5'd3, 5'd7);
        run_init("T5.init");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        chk("T5.x3",   rd1, 32'h0);
        chk("T5.x7",   rd2, 32'h0);
        chk("T5.drop", {31'b0, wrd}, 32'h0);
        check_all("T5.run");
        tick();

        // T4: write presented during init cycle 5 is dropped and flagged.
        step("T4.rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        for (int k = 0; k < C_INIT_CYCLES; k++) begin
            if (k == 5) step("T4.wr", 1'b0, 1'b1, 5'd9, 32'h0000_1234, 5'd9, 5'd2);
            else        step("T4.init", 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd2);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd2);
        chk("T4.x9",   rd1, 32'h0);
        chk("T4.drop", {31'b0, wrd}, 32'h1);
        check_all("T4.run");
        tick();

        // T6: dual-port collision plus a neighbouring old value.
        step("T6.pre", 1'b0, 1'b1, 5'd11, 32'h0B0B_0B0B, 5'd11, 5'd11);
        drive(1'b0, 1'b1, 5'd12, 32'h0F0F_0F0F, 5'd12, 5'd12);
        chk("T6.rd1", rd1, 32'h0F0F_0F0F);
        chk("T6.rd2", rd2, 32'h0F0F_0F0F);
        check_all("T6.same");
        drive(1'b0, 1'b1, 5'd12, 32'h0F0F_0F0F, 5'd11, 5'd12);
        chk("T6.old11", rd1, 32'h0B0B_0B0B);
        check_all("T6.mixed");
        tick();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step("RND",
                 ($urandom_range(0, 79) == 0),
                 1'($urandom),
                 5'($urandom),
                 $urandom,
                 5'($urandom),
                 ($urandom_range(0, 7) == 0) ? a1 : 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_wb_port
`default_nettype wire
